// File: rtl/pipeline_hazard_ctrl_pkg.sv
// pipeline_hazard_ctrl_pkg: opcode values, instruction field positions and
// controller state codes shared by the hazard controller and its detector.
package pipeline_hazard_ctrl_pkg;

    localparam int OPC_W  = 6;
    localparam int REG_W  = 5;
    localparam int RS_MSB = 25;
    localparam int RT_MSB = 20;

    localparam logic [OPC_W-1:0] OP_NOP  = 6'h00;
    localparam logic [OPC_W-1:0] OP_LW   = 6'h23;
    localparam logic [OPC_W-1:0] OP_MUL  = 6'h1c;
    localparam logic [OPC_W-1:0] OP_HALT = 6'h3f;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_X_BUSY   = 2'd1;
    localparam logic [1:0] ST_MEM_WAIT = 2'd2;
    localparam logic [1:0] ST_HALT     = 2'd3;

    // A destination register conflicts with a source only when it is not r0.
    function automatic logic regHazard(input logic [REG_W-1:0] dst,
                                       input logic [REG_W-1:0] src);
        return (dst != '0) && (dst == src);
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use check between the load sitting in X
// (ir2) and the instruction being read in R (ir1).
module hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int IR_W   = 32,
    parameter int OP_MSB = 31
)
(
    input  logic [IR_W-1:0] i_ir1,
    input  logic [IR_W-1:0] i_ir2,
    output logic            o_loadUse
);

    logic [OPC_W-1:0] w_opX;
    logic [REG_W-1:0] w_rtX;
    logic [REG_W-1:0] w_rsR;
    logic [REG_W-1:0] w_rtR;
    logic             w_unused;

    assign w_opX = i_ir2[OP_MSB -: OPC_W];
    assign w_rtX = i_ir2[RT_MSB -: REG_W];
    assign w_rsR = i_ir1[RS_MSB -: REG_W];
    assign w_rtR = i_ir1[RT_MSB -: REG_W];

    // Only the register and opcode fields matter; the rest is sunk here.
    assign w_unused = ^{i_ir1, i_ir2};

    assign o_loadUse = (w_opX == OP_LW) &&
                       (regHazard(w_rtX, w_rsR) || regHazard(w_rtX, w_rtR));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stage-enable and bubble/flush controller for the
// F/R/X/M/W pipeline (load-use, branch flush, multi-cycle MUL, memory wait
// with timeout, halt). Optional performance counters: PIPE_HAZARD_PERF_EN.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int IR_W        = 32,
    parameter int OP_MSB      = 31,
    parameter int MUL_LAT     = 4,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [IR_W-1:0]  ir1,
    input  logic [IR_W-1:0]  ir2,
    input  logic [IR_W-1:0]  ir3,
    input  logic [IR_W-1:0]  ir4,
    input  logic             br_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    input  logic             halt_req,
    output logic             e_f,
    output logic             e_r,
    output logic             e_x,
    output logic             e_m,
    output logic             e_w,
    output logic             flush_fr,
    output logic             bubble_x,
    output logic             bubble_m,
    output logic             halted,
    output logic             mem_err
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] memwait_cnt
`endif
);

    localparam int MUL_W  = $clog2(MUL_LAT + 1);
    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam bit                MUL_HOLD  = (MUL_LAT > 1);
    localparam logic [MUL_W-1:0]  MUL_LOAD  = MUL_W'(MUL_LAT - 1);
    localparam logic [MUL_W-1:0]  MUL_ONE   = MUL_W'(1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    logic [1:0]        r_state;
    logic [1:0]        r_retState;
    logic [MUL_W-1:0]  r_mulCnt;
    logic [WAIT_W-1:0] r_waitCnt;
    logic              r_memErr;
    logic              r_mulDone;

    logic [1:0]        w_nextState;
    logic [1:0]        w_nextRet;
    logic [MUL_W-1:0]  w_nextMul;
    logic [WAIT_W-1:0] w_nextWait;
    logic              w_nextErr;
    logic              w_nextMulDone;
    logic [1:0]        w_evalState;
    logic              w_loadUse;
    logic              w_memStall;
    logic              w_haltReq;
    logic              w_unused;

    hazard_detect #(
        .IR_W   (IR_W),
        .OP_MSB (OP_MSB)
    ) u_hazardDetect (
        .i_ir1     (ir1),
        .i_ir2     (ir2),
        .o_loadUse (w_loadUse)
    );

    assign w_memStall = mem_req && !mem_ready;
    assign w_haltReq  = halt_req || (ir4[OP_MSB -: OPC_W] == OP_HALT);
    // ir3 plays no part in any hazard resolved here.
    assign w_unused   = ^{ir3, ir4};
    // When memory releases, the cycle behaves as the suspended state.
    assign w_evalState = (r_state == ST_MEM_WAIT) ? r_retState : r_state;

    // Next-state and stage-control decode; HALT entry only redirects the
    // next state so the retiring instruction still gets its W enable.
    always_comb begin
        w_nextState   = r_state;
        w_nextRet     = r_retState;
        w_nextMul     = r_mulCnt;
        w_nextWait    = r_waitCnt;
        w_nextErr     = r_memErr;
        w_nextMulDone = r_mulDone;
        e_f = 1'b0; e_r = 1'b0; e_x = 1'b0; e_m = 1'b0; e_w = 1'b0;
        flush_fr = 1'b0; bubble_x = 1'b0; bubble_m = 1'b0;

        if (r_state == ST_HALT) begin
            w_nextState = ST_HALT;
        end else if (w_memStall) begin
            if (r_state == ST_MEM_WAIT) begin
                if (r_waitCnt == WAIT_LAST) begin
                    w_nextErr   = 1'b1;
                    w_nextState = ST_HALT;
                    w_nextWait  = '0;
                end else begin
                    w_nextWait = r_waitCnt + 1'b1;
                end
            end else begin
                w_nextState = ST_MEM_WAIT;
                w_nextRet   = r_state;
                w_nextWait  = '0;
            end
        end else begin
            w_nextWait  = '0;
            w_nextState = w_evalState;
            if (w_evalState == ST_X_BUSY) begin
                e_m = 1'b1; e_w = 1'b1; bubble_m = 1'b1;
                if (r_mulCnt == MUL_ONE) begin
                    w_nextState   = ST_RUN;
                    w_nextMul     = '0;
                    w_nextMulDone = 1'b1;
                end else begin
                    w_nextMul = r_mulCnt - 1'b1;
                end
            end else begin
                e_f = 1'b1; e_r = 1'b1; e_x = 1'b1; e_m = 1'b1; e_w = 1'b1;
                w_nextMulDone = 1'b0;
                if (br_taken) begin
                    flush_fr = 1'b1;
                end else if (w_loadUse) begin
                    e_f = 1'b0; e_r = 1'b0; bubble_x = 1'b1;
                end else if (MUL_HOLD && !r_mulDone &&
                             (ir2[OP_MSB -: OPC_W] == OP_MUL)) begin
                    w_nextState = ST_X_BUSY;
                    w_nextMul   = MUL_LOAD;
                end
            end
        end

        if ((r_state != ST_HALT) && w_haltReq) begin
            w_nextState = ST_HALT;
        end

        if (rst) begin
            e_f = 1'b0; e_r = 1'b0; e_x = 1'b0; e_m = 1'b0; e_w = 1'b0;
            flush_fr = 1'b0; bubble_x = 1'b0; bubble_m = 1'b0;
        end
    end

    assign halted  = (r_state == ST_HALT);
    assign mem_err = r_memErr;

    // Controller state registers, cleared asynchronously by rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_retState <= ST_RUN;
            r_mulCnt   <= '0;
            r_waitCnt  <= '0;
            r_memErr   <= 1'b0;
            r_mulDone  <= 1'b0;
        end else begin
            r_state    <= w_nextState;
            r_retState <= w_nextRet;
            r_mulCnt   <= w_nextMul;
            r_waitCnt  <= w_nextWait;
            r_memErr   <= w_nextErr;
            r_mulDone  <= w_nextMulDone;
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    // Saturating event counters for stalls, flushes and frozen memory waits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt   <= '0;
            flush_cnt   <= '0;
            memwait_cnt <= '0;
        end else begin
            if ((bubble_x || bubble_m) && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_fr && (flush_cnt != '1))
                flush_cnt <= flush_cnt + 1'b1;
            if ((r_state == ST_MEM_WAIT) && w_memStall && (memwait_cnt != '1))
                memwait_cnt <= memwait_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed checks of the hazard controller with
// MUL_LAT = 4 and MEM_TIMEOUT = 8.
module tb_pipeline_hazard_ctrl;

    localparam logic [5:0] T_LW   = 6'h23;
    localparam logic [5:0] T_MUL  = 6'h1c;
    localparam logic [5:0] T_HALT = 6'h3f;

    // Output vector order: e_f e_r e_x e_m e_w flush_fr bubble_x bubble_m halted mem_err
    localparam logic [9:0] V_RUN  = 10'b11111_000_00;
    localparam logic [9:0] V_LU   = 10'b00111_010_00;
    localparam logic [9:0] V_BR   = 10'b11111_100_00;
    localparam logic [9:0] V_XB   = 10'b00011_001_00;
    localparam logic [9:0] V_FRZ  = 10'b00000_000_00;
    localparam logic [9:0] V_HLT  = 10'b00000_000_10;
    localparam logic [9:0] V_HERR = 10'b00000_000_11;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ir1, ir2, ir3, ir4;
    logic        brTaken, memReq, memReady, haltReq;
    logic        eF, eR, eX, eM, eW, flushFr, bubbleX, bubbleM, haltedO, memErr;
    int          testCount = 0;
    int          failCount = 0;
`ifdef PIPE_HAZARD_PERF_EN
    logic [15:0] stallCnt, flushCnt, memwaitCnt;
`endif

    pipeline_hazard_ctrl #(
        .IR_W(32), .OP_MSB(31), .MUL_LAT(4), .MEM_TIMEOUT(8), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .ir1(ir1), .ir2(ir2), .ir3(ir3), .ir4(ir4),
        .br_taken(brTaken), .mem_req(memReq), .mem_ready(memReady), .halt_req(haltReq),
        .e_f(eF), .e_r(eR), .e_x(eX), .e_m(eM), .e_w(eW),
        .flush_fr(flushFr), .bubble_x(bubbleX), .bubble_m(bubbleM),
        .halted(haltedO), .mem_err(memErr)
`ifdef PIPE_HAZARD_PERF_EN
        , .stall_cnt(stallCnt), .flush_cnt(flushCnt), .memwait_cnt(memwaitCnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mkIns(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt);
        return {op, rs, rt, 16'h0000};
    endfunction

    task automatic applyStimulus(input logic [31:0] a1, input logic [31:0] a2,
                                 input logic [31:0] a4, input logic br,
                                 input logic req, input logic rdy, input logic hr);
        ir1 = a1; ir2 = a2; ir3 = 32'h0; ir4 = a4;
        brTaken = br; memReq = req; memReady = rdy; haltReq = hr;
    endtask

    // Samples at the falling edge, then advances to just after the next rising edge.
    task automatic checkOutput(input string tag, input logic [9:0] expected);
        logic [9:0] observed;
        @(negedge clk);
        observed = {eF, eR, eX, eM, eW, flushFr, bubbleX, bubbleM, haltedO, memErr};
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("FAIL %s: observed %b, expected %b", tag, observed, expected);
        end
        @(posedge clk);
        #1;
    endtask

`ifdef PIPE_HAZARD_PERF_EN
    task automatic checkCount(input string tag, input logic [15:0] observed,
                              input logic [15:0] expected);
        testCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask
`endif

    initial begin
        logic [31:0] nop;
        nop = 32'h0;
        rst = 1'b1;
        applyStimulus(mkIns(6'h00, 5'd5, 5'd2), mkIns(T_LW, 5'd1, 5'd5), nop, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("reset_outputs", V_FRZ);
        rst = 1'b0;

        applyStimulus(nop, nop, nop, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("run_idle", V_RUN);

        applyStimulus(mkIns(6'h00, 5'd5, 5'd2), mkIns(T_LW, 5'd1, 5'd5), nop, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("loaduse_rs", V_LU);
`ifdef PIPE_HAZARD_PERF_EN
        checkCount("perf_stall_lu", stallCnt, 16'd1);
`endif
        applyStimulus(mkIns(6'h00, 5'd5, 5'd2), nop, nop, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("loaduse_clear", V_RUN);

        applyStimulus(mkIns(6'h00, 5'd0, 5'd3), mkIns(T_LW, 5'd1, 5'd0), nop, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("lw_r0_nostall", V_RUN);

        applyStimulus(mkIns(6'h00, 5'd4, 5'd9), mkIns(T_LW, 5'd1, 5'd9), nop, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("loaduse_rt", V_LU);

        applyStimulus(mkIns(6'h00, 5'd5, 5'd2), mkIns(T_LW, 5'd1, 5'd5), nop, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("branch_over_lu", V_BR);
        applyStimulus(nop, nop, nop, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("branch_done", V_RUN);

        applyStimulus(nop, mkIns(T_MUL, 5'd3, 5'd4), nop, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("mul_detect", V_RUN);
        checkOutput("mul_busy1", V_XB);
        applyStimulus(nop, mkIns(T_MUL, 5'd3, 5'd4), nop, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("mul_memfreeze1", V_FRZ);
        checkOutput("mul_memfreeze2", V_FRZ);
        applyStimulus(nop, mkIns(T_MUL, 5'd3, 5'd4), nop, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("mul_busy2", V_XB);
        applyStimulus(nop, mkIns(T_MUL, 5'd3, 5'd4), nop, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("mul_busy3", V_XB);
        checkOutput("mul_complete", V_RUN);
        applyStimulus(nop, nop, nop, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("mul_after", V_RUN);
`ifdef PIPE_HAZARD_PERF_EN
        checkCount("perf_stall_mul", stallCnt, 16'd5);
        checkCount("perf_flush", flushCnt, 16'd1);
        checkCount("perf_memwait", memwaitCnt, 16'd1);
`endif

        applyStimulus(nop, nop, mkIns(T_HALT, 5'd0, 5'd0), 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("halt_retire", V_RUN);
        applyStimulus(nop, nop, nop, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("halt_state", V_HLT);
        checkOutput("halt_sticky", V_HLT);
        rst = 1'b1;
        checkOutput("rst_mid_halt", V_FRZ);
        rst = 1'b0;
        checkOutput("run_after_rst", V_RUN);

        applyStimulus(nop, nop, nop, 1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("timeout_enter", V_FRZ);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("timeout_wait%0d", i), V_FRZ);
        end
        checkOutput("timeout_halt", V_HERR);
        applyStimulus(nop, nop, nop, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("timeout_sticky", V_HERR);
        rst = 1'b1;
        checkOutput("timeout_rst", V_FRZ);
        rst = 1'b0;
        checkOutput("timeout_recover", V_RUN);

        applyStimulus(nop, nop, nop, 1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("haltreq_entry", V_RUN);
        applyStimulus(nop, nop, nop, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("haltreq_state", V_HLT);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
